// File: rtl/reset_sequencer.sv
// reset_sequencer: staged reset release for NUM_STAGES downstream domains.
// Waits for a filtered PLL lock, then releases stage 0..NUM_STAGES-1 in order.
//
// Ports:
//   clk            in   single clock, rising edge
//   reset_n_i      in   synchronous active-low reset
//   pll_lock_i     in   PLL lock, already synchronous to clk
//   sw_rst_req_i   in   [NUM_STAGES] level software reset request per stage
//   reset_n_o      out  [NUM_STAGES] active-low stage resets (thermometer)
//   seq_done_o     out  all stages released
//   lock_timeout_o out  sticky: no lock within LOCK_TIMEOUT HOLD cycles

module reset_sequencer #(
   parameter int NUM_STAGES   = 4,
   parameter int STAGE_DELAY  = 16,
   parameter int LOCK_FILTER  = 8,
   parameter int LOCK_TIMEOUT = 4096
) (
   input  logic                  clk,
   input  logic                  reset_n_i,
   input  logic                  pll_lock_i,
   input  logic [NUM_STAGES-1:0] sw_rst_req_i,
   output logic [NUM_STAGES-1:0] reset_n_o,
   output logic                  seq_done_o,
   output logic                  lock_timeout_o
);

   localparam int DW = $clog2(STAGE_DELAY + 1);
   localparam int LW = $clog2(LOCK_FILTER + 1);
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);
   localparam int PW = $clog2(NUM_STAGES + 1);

   localparam logic [DW-1:0] DLY_LAST  = DW'(STAGE_DELAY - 1);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_FILTER - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] TO_MAX    = TW'(LOCK_TIMEOUT);
   localparam logic [PW-1:0] PTR_LAST  = PW'(NUM_STAGES - 1);
   localparam logic [PW-1:0] PTR_END   = PW'(NUM_STAGES);

   localparam logic [1:0] S_HOLD    = 2'd0;
   localparam logic [1:0] S_RELEASE = 2'd1;
   localparam logic [1:0] S_SW_HOLD = 2'd2;
   localparam logic [1:0] S_RUN     = 2'd3;

   logic [1:0]            r_state;
   logic [PW-1:0]         r_ptr;
   logic [DW-1:0]         r_dly;
   logic [LW-1:0]         r_lock;
   logic [TW-1:0]         r_to;
   logic [NUM_STAGES-1:0] r_rst;
   logic                  r_done;
   logic                  r_tmo;

   logic [1:0]            w_state_nx;
   logic [PW-1:0]         w_ptr_nx;
   logic [DW-1:0]         w_dly_nx;
   logic [LW-1:0]         w_lock_nx;
   logic [TW-1:0]         w_to_nx;
   logic [NUM_STAGES-1:0] w_rst_nx;
   logic                  w_done_nx;
   logic                  w_tmo_nx;

   logic                  w_req_any;
   logic [PW-1:0]         w_req_idx;
   logic [PW-1:0]         w_req_ptr;
   logic [PW-1:0]         w_ptr_inc;

   // Bits below p are released; p == NUM_STAGES releases everything.
   function automatic logic [NUM_STAGES-1:0] therm(input logic [PW-1:0] p);
      logic [NUM_STAGES-1:0] v;
      v = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         v[k] = (PW'(k) < p);
      end
      return v;
   endfunction

   // Lowest requesting stage; NUM_STAGES when nothing is requested.
   always_comb begin
      w_req_idx = PTR_END;
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
         if (sw_rst_req_i[k]) begin
            w_req_idx = PW'(k);
         end
      end
   end

   assign w_req_any = |sw_rst_req_i;
   assign w_ptr_inc = r_ptr + PW'(1);

   // In RUN r_ptr already equals NUM_STAGES, so min() covers both states.
   assign w_req_ptr = (w_req_idx < r_ptr) ? w_req_idx : r_ptr;

   always_comb begin
      w_state_nx = r_state;
      w_ptr_nx   = r_ptr;
      w_dly_nx   = r_dly;
      w_lock_nx  = r_lock;
      w_to_nx    = r_to;
      w_rst_nx   = r_rst;
      w_done_nx  = r_done;
      w_tmo_nx   = r_tmo;

      unique case (r_state)
         S_HOLD: begin
            w_rst_nx  = '0;
            w_done_nx = 1'b0;
            if (r_to != TO_MAX) begin
               w_to_nx = r_to + TW'(1);
            end
            if (r_to == TO_LAST) begin
               w_tmo_nx = 1'b1;
            end
            if (!pll_lock_i) begin
               w_lock_nx = '0;
            end else if (r_lock == LOCK_LAST) begin
               w_state_nx = S_RELEASE;
               w_lock_nx  = '0;
               w_ptr_nx   = '0;
               w_dly_nx   = '0;
            end else begin
               w_lock_nx = r_lock + LW'(1);
            end
         end

         S_RELEASE: begin
            if (!pll_lock_i) begin
               w_state_nx = S_HOLD;
               w_rst_nx   = '0;
               w_done_nx  = 1'b0;
               w_lock_nx  = '0;
               w_to_nx    = '0;
               w_ptr_nx   = '0;
               w_dly_nx   = '0;
            end else if (w_req_any) begin
               w_state_nx = S_SW_HOLD;
               w_ptr_nx   = w_req_ptr;
               w_rst_nx   = therm(w_req_ptr);
               w_done_nx  = 1'b0;
               w_dly_nx   = '0;
            end else if (r_dly == DLY_LAST) begin
               w_dly_nx = '0;
               w_ptr_nx = w_ptr_inc;
               w_rst_nx = therm(w_ptr_inc);
               if (r_ptr == PTR_LAST) begin
                  w_state_nx = S_RUN;
                  w_done_nx  = 1'b1;
               end
            end else begin
               w_dly_nx = r_dly + DW'(1);
            end
         end

         S_SW_HOLD: begin
            if (!pll_lock_i) begin
               w_state_nx = S_HOLD;
               w_rst_nx   = '0;
               w_done_nx  = 1'b0;
               w_lock_nx  = '0;
               w_to_nx    = '0;
               w_ptr_nx   = '0;
               w_dly_nx   = '0;
            end else if (w_req_any) begin
               // A lower request widens the held region; higher ones are
               // already covered.
               w_ptr_nx = w_req_ptr;
               w_rst_nx = therm(w_req_ptr);
            end else begin
               w_state_nx = S_RELEASE;
               w_dly_nx   = '0;
            end
         end

         S_RUN: begin
            if (!pll_lock_i) begin
               w_state_nx = S_HOLD;
               w_rst_nx   = '0;
               w_done_nx  = 1'b0;
               w_lock_nx  = '0;
               w_to_nx    = '0;
               w_ptr_nx   = '0;
               w_dly_nx   = '0;
            end else if (w_req_any) begin
               w_state_nx = S_SW_HOLD;
               w_ptr_nx   = w_req_ptr;
               w_rst_nx   = therm(w_req_ptr);
               w_done_nx  = 1'b0;
               w_dly_nx   = '0;
            end
         end

         default: begin
            w_state_nx = S_HOLD;
            w_rst_nx   = '0;
            w_done_nx  = 1'b0;
            w_lock_nx  = '0;
            w_to_nx    = '0;
            w_ptr_nx   = '0;
            w_dly_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n_i) begin
         r_state <= S_HOLD;
         r_ptr   <= '0;
         r_dly   <= '0;
         r_lock  <= '0;
         r_to    <= '0;
         r_rst   <= '0;
         r_done  <= 1'b0;
         r_tmo   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_ptr   <= w_ptr_nx;
         r_dly   <= w_dly_nx;
         r_lock  <= w_lock_nx;
         r_to    <= w_to_nx;
         r_rst   <= w_rst_nx;
         r_done  <= w_done_nx;
         r_tmo   <= w_tmo_nx;
      end
   end

   assign reset_n_o      = r_rst;
   assign seq_done_o     = r_done;
   assign lock_timeout_o = r_tmo;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed table, hand sequences and random stimulus
// checked against a timestamp-based reference model of reset_sequencer.

module tb_reset_sequencer;

   localparam int N  = 4;
   localparam int D  = 16;
   localparam int F  = 8;
   localparam int TO = 64;

   logic         clk;
   logic         rst_n;
   logic         lock;
   logic [N-1:0] req;
   logic [N-1:0] reset_n_o;
   logic         seq_done_o;
   logic         lock_timeout_o;

   int nvec = 0;
   int nerr = 0;

   reset_sequencer #(
      .NUM_STAGES  (N),
      .STAGE_DELAY (D),
      .LOCK_FILTER (F),
      .LOCK_TIMEOUT(TO)
   ) dut (
      .clk           (clk),
      .reset_n_i     (rst_n),
      .pll_lock_i    (lock),
      .sw_rst_req_i  (req),
      .reset_n_o     (reset_n_o),
      .seq_done_o    (seq_done_o),
      .lock_timeout_o(lock_timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: released stage count is derived from the edge at
   // which the current release segment started, not from a delay counter.
   int       m_t     = 0;
   bit       m_wait  = 1'b1;
   bit       m_sw    = 1'b0;
   int       m_run   = 0;
   int       m_hold  = 0;
   bit       m_tmo   = 1'b0;
   int       m_base  = 0;
   int       m_start = 0;
   logic [N-1:0] exp_rst  = '0;
   logic         exp_done = 1'b0;
   logic         exp_tmo  = 1'b0;

   function automatic int released(int base, int start, int t);
      int r;
      r = base + (t - start) / D;
      return (r > N) ? N : r;
   endfunction

   function automatic int lowest(logic [N-1:0] q);
      int lo;
      lo = N;
      for (int k = N - 1; k >= 0; k--) begin
         if (q[k]) lo = k;
      end
      return lo;
   endfunction

   always @(posedge clk) begin : model
      int cur;
      int rel;
      m_t = m_t + 1;
      if (!rst_n) begin
         m_wait = 1'b1; m_sw = 1'b0; m_run = 0;
         m_hold = 0; m_tmo = 1'b0; m_base = 0; m_start = 0;
      end else if (m_wait) begin
         m_hold = m_hold + 1;
         if (m_hold == TO) m_tmo = 1'b1;
         if (lock) begin
            m_run = m_run + 1;
            if (m_run == F) begin
               m_wait = 1'b0; m_run = 0; m_sw = 1'b0;
               m_base = 0; m_start = m_t;
            end
         end else begin
            m_run = 0;
         end
      end else begin
         cur = m_sw ? m_base : released(m_base, m_start, m_t - 1);
         if (!lock) begin
            m_wait = 1'b1; m_run = 0; m_hold = 0;
         end else if (req != '0) begin
            if (lowest(req) < cur) cur = lowest(req);
            m_base = cur;
            m_sw   = 1'b1;
         end else if (m_sw) begin
            m_sw    = 1'b0;
            m_start = m_t;
         end
      end
      if (m_wait) begin
         rel = 0;
      end else if (m_sw) begin
         rel = m_base;
      end else begin
         rel = released(m_base, m_start, m_t);
      end
      exp_rst  = N'((1 << rel) - 1);
      exp_done = !m_wait && !m_sw && (rel == N);
      exp_tmo  = m_tmo;
   end

   task automatic mcheck();
      nvec++;
      if (reset_n_o !== exp_rst || seq_done_o !== exp_done ||
          lock_timeout_o !== exp_tmo) begin
         nerr++;
         $display("FAIL model t=%0d: got rst=%b done=%b tmo=%b want rst=%b done=%b tmo=%b",
                  m_t, reset_n_o, seq_done_o, lock_timeout_o,
                  exp_rst, exp_done, exp_tmo);
      end
   endtask

   task automatic dcheck(input string name, input logic [N-1:0] er,
                         input logic ed, input logic et);
      nvec++;
      if (reset_n_o !== er || seq_done_o !== ed || lock_timeout_o !== et) begin
         nerr++;
         $display("FAIL %s: got rst=%b done=%b tmo=%b want rst=%b done=%b tmo=%b",
                  name, reset_n_o, seq_done_o, lock_timeout_o, er, ed, et);
      end
   endtask

   // Drive inputs away from the rising edge, then compare after it.
   task automatic tick(input logic r, input logic l, input logic [N-1:0] q);
      rst_n = r;
      lock  = l;
      req   = q;
      @(negedge clk);
      mcheck();
   endtask

   task automatic ticks(input int n, input logic l, input logic [N-1:0] q);
      for (int i = 0; i < n; i++) tick(1'b1, l, q);
   endtask

   typedef struct {
      int           at;
      logic [N-1:0] rst;
      logic         done;
   } vec_t;

   vec_t tbl[10];

   initial begin : test
      int   n;
      logic l;
      logic r;
      logic [N-1:0] q;

      // Edge index after reset release -> expected outputs.
      tbl[0] = '{1,  4'b0000, 1'b0};
      tbl[1] = '{8,  4'b0000, 1'b0};
      tbl[2] = '{23, 4'b0000, 1'b0};
      tbl[3] = '{24, 4'b0001, 1'b0};
      tbl[4] = '{39, 4'b0001, 1'b0};
      tbl[5] = '{40, 4'b0011, 1'b0};
      tbl[6] = '{56, 4'b0111, 1'b0};
      tbl[7] = '{71, 4'b0111, 1'b0};
      tbl[8] = '{72, 4'b1111, 1'b1};
      tbl[9] = '{90, 4'b1111, 1'b1};

      rst_n = 1'b0;
      lock  = 1'b1;
      req   = '0;

      // Basic sequence, lock high from start.
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, '0);
      dcheck("reset", 4'b0000, 1'b0, 1'b0);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         while (n < tbl[i].at) begin
            tick(1'b1, 1'b1, '0);
            n++;
         end
         dcheck($sformatf("seq@%0d", tbl[i].at), tbl[i].rst, tbl[i].done, 1'b0);
      end

      // Glitchy lock: the short run must not start sequencing.
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, '0);
      ticks(5, 1'b1, '0);
      dcheck("glitch_hi5", 4'b0000, 1'b0, 1'b0);
      ticks(1, 1'b0, '0);
      ticks(8, 1'b1, '0);
      dcheck("glitch_hi8", 4'b0000, 1'b0, 1'b0);
      ticks(15, 1'b1, '0);
      dcheck("glitch_pre", 4'b0000, 1'b0, 1'b0);
      ticks(1, 1'b1, '0);
      dcheck("glitch_s0", 4'b0001, 1'b0, 1'b0);

      // Lock timeout, then a late lock keeps the sticky flag.
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, '0);
      ticks(63, 1'b0, '0);
      dcheck("tmo_63", 4'b0000, 1'b0, 1'b0);
      ticks(1, 1'b0, '0);
      dcheck("tmo_64", 4'b0000, 1'b0, 1'b1);
      ticks(F + 4 * D, 1'b1, '0);
      dcheck("tmo_run", 4'b1111, 1'b1, 1'b1);

      // Software request on stage 2 from RUN.
      ticks(1, 1'b1, 4'b0100);
      dcheck("sw2_hold", 4'b0011, 1'b0, 1'b1);
      ticks(9, 1'b1, 4'b0100);
      dcheck("sw2_held", 4'b0011, 1'b0, 1'b1);
      ticks(16, 1'b1, '0);
      dcheck("sw2_pre", 4'b0011, 1'b0, 1'b1);
      ticks(1, 1'b1, '0);
      dcheck("sw2_s2", 4'b0111, 1'b0, 1'b1);
      ticks(15, 1'b1, '0);
      dcheck("sw2_pre3", 4'b0111, 1'b0, 1'b1);
      ticks(1, 1'b1, '0);
      dcheck("sw2_done", 4'b1111, 1'b1, 1'b1);

      // Lower request while already held.
      ticks(1, 1'b1, 4'b1000);
      dcheck("sw3_hold", 4'b0111, 1'b0, 1'b1);
      ticks(1, 1'b1, 4'b0010);
      dcheck("sw1_lower", 4'b0001, 1'b0, 1'b1);
      ticks(1 + D, 1'b1, '0);
      dcheck("sw1_s1", 4'b0011, 1'b0, 1'b1);
      ticks(2 * D, 1'b1, '0);
      dcheck("sw1_done", 4'b1111, 1'b1, 1'b1);

      // Lock loss beats a same-edge software request.
      ticks(1, 1'b0, 4'b0001);
      dcheck("loss_hold", 4'b0000, 1'b0, 1'b1);
      ticks(F + 4 * D - 1, 1'b1, '0);
      dcheck("loss_pre", 4'b0111, 1'b0, 1'b1);
      ticks(1, 1'b1, '0);
      dcheck("loss_done", 4'b1111, 1'b1, 1'b1);

      // Random mix against the model.
      l = 1'b1;
      q = '0;
      for (int i = 0; i < 6000; i++) begin
         if (l && $urandom_range(0, 99) < 1) l = 1'b0;
         else if (!l && $urandom_range(0, 99) < 3) l = 1'b1;
         if (q == '0) begin
            if ($urandom_range(0, 99) < 1) q = N'($urandom_range(1, 15));
         end else if ($urandom_range(0, 99) < 8) begin
            q = ($urandom_range(0, 1) == 1) ? N'($urandom_range(1, 15)) : '0;
         end
         r = ($urandom_range(0, 999) < 2) ? 1'b0 : 1'b1;
         tick(r, l, q);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
